// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port and memory-side bus of the arbiter.
// The arbiter uses the slave view; the environment drives the master view.
interface mem_arbiter_if #(
    parameter int AW = 32
);
    logic          iReq;
    logic [AW-1:0] iAddr;
    logic          iGnt;
    logic          iRvalid;
    logic [31:0]   iRdata;

    logic          dReq;
    logic          dWen;
    logic [AW-1:0] dAddr;
    logic [31:0]   dWdata;
    logic          dGnt;
    logic          dRvalid;
    logic [31:0]   dRdata;

    logic          memReq;
    logic          memWen;
    logic [AW-1:0] memAddr;
    logic [31:0]   memWdata;
    logic [31:0]   memRdata;
    logic          memAck;

    modport slave (
        input  iReq, iAddr, dReq, dWen, dAddr, dWdata, memRdata, memAck,
        output iGnt, iRvalid, iRdata, dGnt, dRvalid, dRdata,
               memReq, memWen, memAddr, memWdata
    );

    modport master (
        output iReq, iAddr, dReq, dWen, dAddr, dWdata, memRdata, memAck,
        input  iGnt, iRvalid, iRdata, dGnt, dRvalid, dRdata,
               memReq, memWen, memAddr, memWdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-outstanding memory bus.
// Data port has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [SW-1:0] starve_cnt;
    logic          i_gnt;
    logic          d_gnt;
    logic [AW-1:0] grant_addr;

    logic          mem_req;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          i_rvalid;
    logic          d_rvalid;
    logic [31:0]   i_rdata;
    logic [31:0]   d_rdata;

    // Grants are masked during reset so nothing is accepted in a reset cycle.
    always_comb begin
        state_d    = state_q;
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        grant_addr = bus.iAddr;
        case (state_q)
            IDLE: begin
                if (!rst) begin
                    if (bus.dReq && !(bus.iReq && (starve_cnt == LIMIT))) begin
                        d_gnt      = 1'b1;
                        grant_addr = bus.dAddr;
                        state_d    = BUSY_D;
                    end else if (bus.iReq) begin
                        i_gnt   = 1'b1;
                        state_d = BUSY_I;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.memAck) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state_q  <= state_d;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;

            if (i_gnt || d_gnt) begin
                mem_req   <= 1'b1;
                mem_wen   <= d_gnt && bus.dWen;
                mem_addr  <= grant_addr;
                mem_wdata <= d_gnt ? bus.dWdata : 32'd0;
            end

            if (i_gnt) begin
                starve_cnt <= '0;
            end else if (d_gnt && bus.iReq && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            // Bus fields other than memReq keep their last value after completion.
            if ((state_q != IDLE) && bus.memAck) begin
                mem_req <= 1'b0;
                if (state_q == BUSY_I) begin
                    i_rvalid <= 1'b1;
                    i_rdata  <= bus.memRdata;
                end else begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= mem_wen ? 32'd0 : bus.memRdata;
                end
            end
        end
    end

    assign bus.iGnt     = i_gnt;
    assign bus.dGnt     = d_gnt;
    assign bus.iRvalid  = i_rvalid;
    assign bus.dRvalid  = d_rvalid;
    assign bus.iRdata   = i_rdata;
    assign bus.dRdata   = d_rdata;
    assign bus.memReq   = mem_req;
    assign bus.memWen   = mem_wen;
    assign bus.memAddr  = mem_addr;
    assign bus.memWdata = mem_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1ns after posedge, outputs checked 2ns after.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32)) bus();

    mem_arbiter #(.STARVE_LIMIT(4), .AW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.iReq = 0; bus.iAddr = '0; bus.dReq = 0; bus.dWen = 0;
        bus.dAddr = '0; bus.dWdata = '0; bus.memRdata = '0; bus.memAck = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        repeat (3) tick();
        rst = 0;
        #1;
        checks++; if (bus.memReq !== 1'b0 || bus.memWen !== 1'b0) begin errors++; $display("FAIL reset_memreq: got req=%b wen=%b want 0 0", bus.memReq, bus.memWen); end
        checks++; if (bus.memAddr !== 32'h0 || bus.memWdata !== 32'h0) begin errors++; $display("FAIL reset_membus: got addr=%h wdata=%h want 0 0", bus.memAddr, bus.memWdata); end
        checks++; if ({bus.iGnt, bus.dGnt, bus.iRvalid, bus.dRvalid} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {bus.iGnt, bus.dGnt, bus.iRvalid, bus.dRvalid}); end
        checks++; if (bus.iRdata !== 32'h0 || bus.dRdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got i=%h d=%h want 0 0", bus.iRdata, bus.dRdata); end
        tick();
    endtask

    task automatic test_fetch_read();
        bus.iReq = 1; bus.iAddr = 32'h10;
        #1;
        checks++; if (bus.iGnt !== 1'b1 || bus.dGnt !== 1'b0 || bus.memReq !== 1'b0) begin errors++; $display("FAIL fetch_gnt: got ignt=%b dgnt=%b memreq=%b want 1 0 0", bus.iGnt, bus.dGnt, bus.memReq); end
        tick();
        bus.iReq = 0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin bus.memAck = 1; bus.memRdata = 32'hDEADBEEF; end
            #1;
            checks++; if (bus.memReq !== 1'b1 || bus.memAddr !== 32'h10 || bus.memWen !== 1'b0) begin errors++; $display("FAIL fetch_bus_c%0d: got req=%b addr=%h wen=%b want 1 10 0", c, bus.memReq, bus.memAddr, bus.memWen); end
            checks++; if (bus.iRvalid !== 1'b0) begin errors++; $display("FAIL fetch_early_valid_c%0d: got %b want 0", c, bus.iRvalid); end
            tick();
        end
        bus.memAck = 0; bus.memRdata = 32'h0;
        #1;
        checks++; if (bus.iRvalid !== 1'b1 || bus.iRdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rvalid: got v=%b d=%h want 1 deadbeef", bus.iRvalid, bus.iRdata); end
        checks++; if (bus.memReq !== 1'b0) begin errors++; $display("FAIL fetch_memreq_drop: got %b want 0", bus.memReq); end
        tick();
        #1;
        checks++; if (bus.iRvalid !== 1'b0 || bus.iRdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_hold: got v=%b d=%h want 0 deadbeef", bus.iRvalid, bus.iRdata); end
    endtask

    task automatic test_back_to_back();
        bus.dReq = 1; bus.dWen = 0; bus.dAddr = 32'h40;
        #1;
        checks++; if (bus.dGnt !== 1'b1 || bus.iGnt !== 1'b0) begin errors++; $display("FAIL b2b_gnt0: got dgnt=%b ignt=%b want 1 0", bus.dGnt, bus.iGnt); end
        tick();
        bus.dReq = 0; bus.memAck = 1; bus.memRdata = 32'hA1;
        #1;
        checks++; if (bus.memReq !== 1'b1 || bus.memAddr !== 32'h40 || bus.memWen !== 1'b0) begin errors++; $display("FAIL b2b_bus1: got req=%b addr=%h wen=%b want 1 40 0", bus.memReq, bus.memAddr, bus.memWen); end
        tick();
        bus.memAck = 0;
        #1;
        checks++; if (bus.dRvalid !== 1'b1 || bus.dRdata !== 32'hA1 || bus.memReq !== 1'b0) begin errors++; $display("FAIL b2b_valid2: got v=%b d=%h req=%b want 1 a1 0", bus.dRvalid, bus.dRdata, bus.memReq); end
        tick();
        bus.dReq = 1; bus.dAddr = 32'h44;
        #1;
        checks++; if (bus.dGnt !== 1'b1 || bus.dRvalid !== 1'b0 || bus.dRdata !== 32'hA1) begin errors++; $display("FAIL b2b_gnt3: got gnt=%b v=%b d=%h want 1 0 a1", bus.dGnt, bus.dRvalid, bus.dRdata); end
        tick();
        bus.dReq = 0; bus.dAddr = 32'h0; bus.memAck = 1; bus.memRdata = 32'hB2;
        #1;
        checks++; if (bus.memReq !== 1'b1 || bus.memAddr !== 32'h44) begin errors++; $display("FAIL b2b_bus4: got req=%b addr=%h want 1 44", bus.memReq, bus.memAddr); end
        tick();
        bus.memAck = 0;
        #1;
        checks++; if (bus.dRvalid !== 1'b1 || bus.dRdata !== 32'hB2) begin errors++; $display("FAIL b2b_valid5: got v=%b d=%h want 1 b2", bus.dRvalid, bus.dRdata); end
        tick();
    endtask

    task automatic test_priority_write();
        bus.iReq = 1; bus.iAddr = 32'h30;
        bus.dReq = 1; bus.dWen = 1; bus.dAddr = 32'h20; bus.dWdata = 32'h55;
        #1;
        checks++; if (bus.dGnt !== 1'b1 || bus.iGnt !== 1'b0) begin errors++; $display("FAIL prio_gnt: got dgnt=%b ignt=%b want 1 0", bus.dGnt, bus.iGnt); end
        tick();
        bus.dReq = 0; bus.dWen = 0; bus.memAck = 1; bus.memRdata = 32'hCAFE;
        #1;
        checks++; if (bus.memReq !== 1'b1 || bus.memWen !== 1'b1 || bus.memAddr !== 32'h20 || bus.memWdata !== 32'h55) begin errors++; $display("FAIL prio_wr_bus: got req=%b wen=%b addr=%h wd=%h want 1 1 20 55", bus.memReq, bus.memWen, bus.memAddr, bus.memWdata); end
        checks++; if (bus.iGnt !== 1'b0) begin errors++; $display("FAIL prio_busy_ignt: got %b want 0", bus.iGnt); end
        tick();
        bus.memAck = 0;
        #1;
        checks++; if (bus.dRvalid !== 1'b1 || bus.dRdata !== 32'h0) begin errors++; $display("FAIL prio_wr_done: got v=%b d=%h want 1 0", bus.dRvalid, bus.dRdata); end
        checks++; if (bus.iGnt !== 1'b1) begin errors++; $display("FAIL prio_then_fetch: got %b want 1", bus.iGnt); end
        tick();
        bus.iReq = 0; bus.memAck = 1; bus.memRdata = 32'h1234;
        #1;
        checks++; if (bus.memAddr !== 32'h30 || bus.memWen !== 1'b0) begin errors++; $display("FAIL prio_fetch_bus: got addr=%h wen=%b want 30 0", bus.memAddr, bus.memWen); end
        tick();
        bus.memAck = 0;
        #1;
        checks++; if (bus.iRvalid !== 1'b1 || bus.iRdata !== 32'h1234 || bus.dRvalid !== 1'b0) begin errors++; $display("FAIL prio_fetch_done: got iv=%b id=%h dv=%b want 1 1234 0", bus.iRvalid, bus.iRdata, bus.dRvalid); end
        tick();
    endtask

    task automatic test_starvation();
        int  ndg = 0;
        bit  seen_i = 0;
        bus.iReq = 1; bus.iAddr = 32'h70;
        bus.dReq = 1; bus.dWen = 0; bus.dAddr = 32'h80; bus.memRdata = 32'h5;
        for (int c = 0; c < 40 && !seen_i; c++) begin
            bus.memAck = bus.memReq;
            #1;
            if (bus.dGnt === 1'b1) ndg++;
            if (bus.iGnt === 1'b1) seen_i = 1;
            else tick();
        end
        checks++; if (seen_i !== 1'b1) begin errors++; $display("FAIL starve_timeout: got no iGnt within 40 cycles, want one"); end
        checks++; if (ndg != 4) begin errors++; $display("FAIL starve_count: got %0d data grants want 4", ndg); end
        tick();
        bus.iReq = 0; bus.dReq = 0; bus.memAck = 1; bus.memRdata = 32'h77;
        #1;
        checks++; if (bus.memReq !== 1'b1 || bus.memAddr !== 32'h70) begin errors++; $display("FAIL starve_fetch_bus: got req=%b addr=%h want 1 70", bus.memReq, bus.memAddr); end
        tick();
        bus.memAck = 0;
        #1;
        checks++; if (bus.iRvalid !== 1'b1 || bus.iRdata !== 32'h77) begin errors++; $display("FAIL starve_fetch_done: got v=%b d=%h want 1 77", bus.iRvalid, bus.iRdata); end
        checks++; if (dut.starve_cnt !== 3'd0) begin errors++; $display("FAIL starve_clear: got %0d want 0", dut.starve_cnt); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.dReq = 1; bus.dWen = 0; bus.dAddr = 32'h50;
        #1;
        checks++; if (bus.dGnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt: got %b want 1", bus.dGnt); end
        tick();
        bus.dReq = 0; rst = 1;
        tick();
        rst = 0; bus.memAck = 1; bus.memRdata = 32'h99;
        #1;
        checks++; if (bus.memReq !== 1'b0 || bus.dRvalid !== 1'b0) begin errors++; $display("FAIL rstmid_cleared: got req=%b dv=%b want 0 0", bus.memReq, bus.dRvalid); end
        tick();
        bus.memAck = 0;
        #1;
        checks++; if (bus.dRvalid !== 1'b0 || bus.dRdata !== 32'h0 || bus.memReq !== 1'b0) begin errors++; $display("FAIL rstmid_ack_ignored: got dv=%b d=%h req=%b want 0 0 0", bus.dRvalid, bus.dRdata, bus.memReq); end
        bus.iReq = 1; bus.iAddr = 32'h60;
        #1;
        checks++; if (bus.iGnt !== 1'b1) begin errors++; $display("FAIL rstmid_next_gnt: got %b want 1", bus.iGnt); end
        tick();
        bus.iReq = 0; bus.memAck = 1; bus.memRdata = 32'h66;
        #1;
        checks++; if (bus.memReq !== 1'b1 || bus.memAddr !== 32'h60) begin errors++; $display("FAIL rstmid_next_bus: got req=%b addr=%h want 1 60", bus.memReq, bus.memAddr); end
        tick();
        bus.memAck = 0;
        #1;
        checks++; if (bus.iRvalid !== 1'b1 || bus.iRdata !== 32'h66 || bus.dRvalid !== 1'b0) begin errors++; $display("FAIL rstmid_next_done: got iv=%b id=%h dv=%b want 1 66 0", bus.iRvalid, bus.iRdata, bus.dRvalid); end
        tick();
    endtask

    task automatic test_idle_ack();
        bus.memAck = 1; bus.memRdata = 32'hFFFF;
        #1;
        checks++; if ({bus.iGnt, bus.dGnt, bus.iRvalid, bus.dRvalid, bus.memReq} !== 5'b0) begin errors++; $display("FAIL idleack_c0: got %b want 00000", {bus.iGnt, bus.dGnt, bus.iRvalid, bus.dRvalid, bus.memReq}); end
        tick();
        bus.memAck = 0;
        for (int c = 1; c <= 2; c++) begin
            #1;
            checks++; if (bus.iRvalid !== 1'b0 || bus.dRvalid !== 1'b0 || bus.memReq !== 1'b0) begin errors++; $display("FAIL idleack_pulse_c%0d: got iv=%b dv=%b req=%b want 0 0 0", c, bus.iRvalid, bus.dRvalid, bus.memReq); end
            checks++; if (bus.iRdata !== 32'h66 || bus.dRdata !== 32'h0 || bus.memAddr !== 32'h60) begin errors++; $display("FAIL idleack_hold_c%0d: got id=%h dd=%h addr=%h want 66 0 60", c, bus.iRdata, bus.dRdata, bus.memAddr); end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch_read();
        test_back_to_back();
        test_priority_write();
        test_starvation();
        test_reset_mid();
        test_idle_ack();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while a fetch request waits.
REQ-002 Parameter AW, default 32: address width.
REQ-003 clk  in  1  clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 iReq  in  1  fetch request pending.
REQ-006 iAddr  in  AW  fetch address.
REQ-007 iGnt  out  1  one-cycle pulse: fetch request accepted.
REQ-008 iRvalid  out  1  one-cycle pulse: iRdata valid.
REQ-009 iRdata  out  32  fetch read data.
REQ-010 dReq  in  1  data request pending.
REQ-011 dWen  in  1  data request is a write.
REQ-012 dAddr  in  AW  data address.
REQ-013 dWdata  in  32  data write value.
REQ-014 dGnt  out  1  one-cycle pulse: data request accepted.
REQ-015 dRvalid  out  1  one-cycle pulse: dRdata valid (read) or write complete.
REQ-016 dRdata  out  32  data read value; 0 on write completion.
REQ-017 memReq  out  1  memory transaction active.
REQ-018 memWen  out  1  memory write.
REQ-019 memAddr  out  AW  memory address.
REQ-020 memWdata  out  32  memory write data.
REQ-021 memRdata  in  32  memory read data, valid with memAck.
REQ-022 memAck  in  1  memory completes current transaction (variable latency, 1 cycle minimum).

Function
REQ-023 States: IDLE, BUSY_I, BUSY_D; single outstanding transaction.
REQ-024 IDLE, no request: remain IDLE, no grant.
REQ-025 IDLE, only iReq: iGnt=1 that cycle, latch iAddr, memWen=0, next BUSY_I.
REQ-026 IDLE, only dReq: dGnt=1 that cycle, latch dAddr/dWdata/dWen, next BUSY_D.
REQ-027 IDLE, both requests: data wins unless starveCnt == STARVE_LIMIT, then fetch wins.
REQ-028 starveCnt: increments (saturating at STARVE_LIMIT) on each data grant while iReq=1; clears on any fetch grant; unchanged otherwise.
REQ-029 memReq, memWen, memAddr, memWdata registered: valid from cycle after grant, held stable until memAck cycle inclusive.
REQ-030 BUSY_x, memAck=0: hold; requester inputs ignored.
REQ-031 BUSY_x, memAck=1: capture memRdata (or 0 for write), next IDLE, memReq=0 next cycle.
REQ-032 xRvalid pulses in cycle after memAck, with xRdata; xRdata holds until next completion for that port.
REQ-033 Arbitration may grant a new request in the same IDLE cycle xRvalid pulses; minimum throughput: one transaction per (ack latency + 2) cycles.
REQ-034 Requester deasserts req cycle after its gnt; req high in IDLE always treated as new request.
REQ-035 memAck in IDLE ignored; no valid pulse, no state change.
REQ-036 iGnt and dGnt never both 1; at most one xRvalid per cycle.

Reset
REQ-037 rst=1 in any state: next cycle state IDLE, starveCnt=0, memReq=0, memWen=0, memAddr=0, memWdata=0, iGnt=dGnt=0, iRvalid=dRvalid=0, iRdata=dRdata=0.
REQ-038 Reset mid-transaction abandons it: no xRvalid for that transaction; memAck after reset ignored per REQ-035.

Verification
REQ-039 Fetch read iAddr=0x10, memAck 2 cycles after memReq rises with memRdata=0xDEADBEEF -> iGnt cycle 0, memReq cycles 1-3 addr 0x10, iRvalid cycle 4, iRdata=0xDEADBEEF.
REQ-040 Simultaneous iReq/dReq (dWen=1, dAddr=0x20, dWdata=0x55), ack latency 1 -> dGnt first, memWen=1 addr 0x20 data 0x55, dRvalid with dRdata=0, then iGnt.
REQ-041 dReq held continuously with iReq, STARVE_LIMIT=4 -> exactly 4 dGnt then iGnt; starveCnt returns to 0.
REQ-042 rst asserted while BUSY_D, memAck one cycle later -> no dRvalid, memReq=0, state IDLE, next iReq granted normally.
REQ-043 memAck pulsed in IDLE, no requests -> all outputs unchanged, no valid pulses.
REQ-044 Back-to-back data reads, ack latency 1 -> dGnt cycles 0 and 3, dRvalid cycles 2 and 5, memAddr stable throughout each memReq window.
